// File: rtl/result_monitor_if.sv
// Bundle of the control, watched-value and status signals of result_monitor.
// The master side (run controller) drives Start/Clear/Values and reads status;
// the slave side is the monitor itself.
interface result_monitor_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 16
) ();
    logic                      Start;
    logic                      Clear;
    logic [CHANNELS*WIDTH-1:0] Values;
    logic                      Busy;
    logic                      Done;
    logic                      Timeout;
    logic [CNT_W-1:0]          CycleCount;
    logic [CHANNELS-1:0]       ChangeMask;
    logic [CHANNELS*WIDTH-1:0] Snapshot;

    modport master (
        output Start, Clear, Values,
        input  Busy, Done, Timeout, CycleCount, ChangeMask, Snapshot
    );

    modport slave (
        input  Start, Clear, Values,
        output Busy, Done, Timeout, CycleCount, ChangeMask, Snapshot
    );
endinterface

// File: rtl/result_monitor.sv
// Result monitor: after a Start request and a short warm-up, watches a set of
// register channels and declares the result settled once every channel has
// stayed unchanged for STABLE_CYCLES consecutive cycles, or times out after
// TIMEOUT_CYCLES monitored cycles. The final values are snapshotted and all
// status is frozen until Clear.
module result_monitor #(
    parameter int WIDTH          = 32,
    parameter int CHANNELS       = 2,
    parameter int STABLE_CYCLES  = 16,
    parameter int WARMUP_CYCLES  = 4,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic            Clk,
    input  logic            Reset,
    result_monitor_if.slave mon
);

    localparam int VW = CHANNELS * WIDTH;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WARMUP = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_TOUT   = 3'd4;

    localparam logic [7:0]       WARM_LAST   = 8'(WARMUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_VAL  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};

    // Per-channel inequality between current and previously sampled values.
    function automatic logic [CHANNELS-1:0] chan_diff(
        input logic [VW-1:0] cur,
        input logic [VW-1:0] prev
    );
        logic [CHANNELS-1:0] d;
        d = {CHANNELS{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            d[c] = (cur[c*WIDTH +: WIDTH] != prev[c*WIDTH +: WIDTH]);
        end
        return d;
    endfunction

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    // State and datapath registers
    logic [2:0]          state_r;
    logic [7:0]          warm_cnt_r;
    logic [CNT_W-1:0]    stab_cnt_r;
    logic [VW-1:0]       prev_r;
    logic [CNT_W-1:0]    cycle_count_r;
    logic [CHANNELS-1:0] change_mask_r;
    logic [VW-1:0]       snapshot_r;
    logic                busy_r;
    logic                done_r;
    logic                timeout_r;

    // Next-state values
    logic [2:0]          state_nxt_s;
    logic [7:0]          warm_cnt_nxt_s;
    logic [CNT_W-1:0]    stab_cnt_nxt_s;
    logic [VW-1:0]       prev_nxt_s;
    logic [CNT_W-1:0]    cycle_count_nxt_s;
    logic [CHANNELS-1:0] change_mask_nxt_s;
    logic [VW-1:0]       snapshot_nxt_s;

    // RUN-cycle helpers
    logic [CHANNELS-1:0] diff_s;
    logic [CNT_W-1:0]    stab_run_s;
    logic [CNT_W-1:0]    cc_run_s;
    logic                hit_stable_s;
    logic                hit_timeout_s;

    // Compare/count terms used on every RUN cycle.
    always_comb begin
        diff_s = chan_diff(mon.Values, prev_r);
        if (|diff_s) begin
            stab_run_s = CNT_ZERO;
        end else begin
            stab_run_s = stab_cnt_r + CNT_ONE;
        end
        cc_run_s      = sat_inc(cycle_count_r);
        hit_stable_s  = (stab_run_s == STABLE_VAL);
        hit_timeout_s = (cc_run_s == TIMEOUT_VAL);
    end

    // Next-state and next-datapath logic of the monitor FSM.
    always_comb begin
        state_nxt_s       = state_r;
        warm_cnt_nxt_s    = warm_cnt_r;
        stab_cnt_nxt_s    = stab_cnt_r;
        prev_nxt_s        = prev_r;
        cycle_count_nxt_s = cycle_count_r;
        change_mask_nxt_s = change_mask_r;
        snapshot_nxt_s    = snapshot_r;
        case (state_r)
            ST_IDLE: begin
                // Clear has priority over Start here.
                if (!mon.Clear && mon.Start) begin
                    state_nxt_s       = ST_WARMUP;
                    warm_cnt_nxt_s    = 8'd0;
                    stab_cnt_nxt_s    = CNT_ZERO;
                    cycle_count_nxt_s = CNT_ZERO;
                    change_mask_nxt_s = {CHANNELS{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WARMUP: begin
                if (mon.Clear) begin
                    state_nxt_s = ST_IDLE;
                end else if (warm_cnt_r == WARM_LAST) begin
                    // Last warm-up cycle seeds the comparison baseline.
                    prev_nxt_s  = mon.Values;
                    state_nxt_s = ST_RUN;
                end else begin
                    warm_cnt_nxt_s = warm_cnt_r + 8'd1;
                end
            end
            ST_RUN: begin
                if (mon.Clear) begin
                    // Abort keeps CycleCount/ChangeMask/Snapshot as they are.
                    state_nxt_s = ST_IDLE;
                end else begin
                    prev_nxt_s        = mon.Values;
                    stab_cnt_nxt_s    = stab_run_s;
                    cycle_count_nxt_s = cc_run_s;
                    change_mask_nxt_s = change_mask_r | diff_s;
                    // Stability is checked first so it wins a same-cycle tie.
                    if (hit_stable_s) begin
                        state_nxt_s    = ST_DONE;
                        snapshot_nxt_s = mon.Values;
                    end else if (hit_timeout_s) begin
                        state_nxt_s    = ST_TOUT;
                        snapshot_nxt_s = mon.Values;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
            end
            ST_DONE, ST_TOUT: begin
                // Frozen until acknowledged; Start is ignored.
                if (mon.Clear) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State/datapath registers with synchronous active-low reset; status
    // flags are derived from the next state so they line up with it.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_r       <= ST_IDLE;
            warm_cnt_r    <= 8'd0;
            stab_cnt_r    <= CNT_ZERO;
            prev_r        <= {VW{1'b0}};
            cycle_count_r <= CNT_ZERO;
            change_mask_r <= {CHANNELS{1'b0}};
            snapshot_r    <= {VW{1'b0}};
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            timeout_r     <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            warm_cnt_r    <= warm_cnt_nxt_s;
            stab_cnt_r    <= stab_cnt_nxt_s;
            prev_r        <= prev_nxt_s;
            cycle_count_r <= cycle_count_nxt_s;
            change_mask_r <= change_mask_nxt_s;
            snapshot_r    <= snapshot_nxt_s;
            busy_r        <= (state_nxt_s == ST_WARMUP) || (state_nxt_s == ST_RUN);
            done_r        <= (state_nxt_s == ST_DONE);
            timeout_r     <= (state_nxt_s == ST_TOUT);
        end
    end

    assign mon.Busy       = busy_r;
    assign mon.Done       = done_r;
    assign mon.Timeout    = timeout_r;
    assign mon.CycleCount = cycle_count_r;
    assign mon.ChangeMask = change_mask_r;
    assign mon.Snapshot   = snapshot_r;

endmodule

// File: tb/tb_result_monitor.sv
// Scoreboard bench for result_monitor: three instances (default, short
// timeout, stable==timeout tie) share stimulus; one is observed at a time.
module tb_result_monitor;

    localparam int WARM = 4;

    logic        Clk;
    logic        Reset;
    logic        start_s;
    logic        clear_s;
    logic [63:0] values_s;
    int          sel;

    logic        o_busy;
    logic        o_done;
    logic        o_tout;
    logic [15:0] o_cc;
    logic [1:0]  o_mask;
    logic [63:0] o_snap;

    int n_checks;
    int n_pass;

    typedef struct {
        int          lat;
        logic        done;
        logic        tout;
        logic [15:0] cc;
        logic [1:0]  mask;
        logic [63:0] snap;
    } exp_t;

    exp_t sb_q[$];

    result_monitor_if #(.WIDTH(32), .CHANNELS(2), .CNT_W(16)) if0 ();
    result_monitor_if #(.WIDTH(32), .CHANNELS(2), .CNT_W(16)) if1 ();
    result_monitor_if #(.WIDTH(32), .CHANNELS(2), .CNT_W(16)) if2 ();

    assign if0.Start = start_s;  assign if0.Clear = clear_s;  assign if0.Values = values_s;
    assign if1.Start = start_s;  assign if1.Clear = clear_s;  assign if1.Values = values_s;
    assign if2.Start = start_s;  assign if2.Clear = clear_s;  assign if2.Values = values_s;

    result_monitor u0 (.Clk(Clk), .Reset(Reset), .mon(if0));
    result_monitor #(.TIMEOUT_CYCLES(20)) u1 (.Clk(Clk), .Reset(Reset), .mon(if1));
    result_monitor #(.STABLE_CYCLES(8), .TIMEOUT_CYCLES(8)) u2 (.Clk(Clk), .Reset(Reset), .mon(if2));

    // Clock generation.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Select which instance is being observed.
    always_comb begin
        case (sel)
            1: begin
                o_busy = if1.Busy; o_done = if1.Done; o_tout = if1.Timeout;
                o_cc = if1.CycleCount; o_mask = if1.ChangeMask; o_snap = if1.Snapshot;
            end
            2: begin
                o_busy = if2.Busy; o_done = if2.Done; o_tout = if2.Timeout;
                o_cc = if2.CycleCount; o_mask = if2.ChangeMask; o_snap = if2.Snapshot;
            end
            default: begin
                o_busy = if0.Busy; o_done = if0.Done; o_tout = if0.Timeout;
                o_cc = if0.CycleCount; o_mask = if0.ChangeMask; o_snap = if0.Snapshot;
            end
        endcase
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Stimulus value patterns, indexed by RUN cycle r (r<=0: warm-up/baseline).
    function automatic logic [63:0] vals(input int mode, input int r);
        int          rr;
        logic [31:0] c0;
        logic [31:0] c1;
        rr = (r < 0) ? 0 : r;
        case (mode)
            1: begin
                c0 = 32'h0000_1234;
                c1 = (rr < 3) ? 32'h0000_0040 : ((rr < 10) ? 32'h0000_0041 : 32'h0000_0042);
            end
            2: begin
                c0 = 32'h0000_0100 + 32'(rr & 1);
                c1 = 32'h0000_0077;
            end
            3: begin
                c0 = 32'h0000_00C3;
                c1 = 32'h0000_003C;
            end
            default: begin
                c0 = 32'h0000_0005;
                c1 = 32'h0000_000A;
            end
        endcase
        return {c1, c0};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_start(input int mode);
        values_s = vals(mode, 0);
        start_s  = 1'b1;
        tick();
        start_s  = 1'b0;
    endtask

    task automatic do_clear();
        clear_s = 1'b1;
        tick();
        clear_s = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        check_val({tag, "_busy"}, 64'(o_busy), 64'd0);
        check_val({tag, "_done"}, 64'(o_done), 64'd0);
        check_val({tag, "_tout"}, 64'(o_tout), 64'd0);
        check_val({tag, "_cc"},   64'(o_cc),   64'd0);
        check_val({tag, "_mask"}, 64'(o_mask), 64'd0);
        check_val({tag, "_snap"}, o_snap,      64'd0);
    endtask

    // Start a run, stream the pattern, wait (bounded) for Done/Timeout and
    // compare against the expectation pushed on the scoreboard.
    task automatic run_case(input string tag, input int mode, input int s, input exp_t e);
        exp_t x;
        int   lat;
        int   busy_n;
        bit   hit;
        sel = s;
        sb_q.push_back(e);
        pulse_start(mode);
        busy_n = o_busy ? 1 : 0;
        hit    = 1'b0;
        lat    = 0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (o_done || o_tout) begin
                hit = 1'b1;
                lat = k;
                break;
            end
            if (o_busy) busy_n++;
            values_s = vals(mode, k + 1 - WARM);
        end
        x = sb_q.pop_front();
        check_val({tag, "_finished"}, 64'(hit), 64'd1);
        check_val({tag, "_latency"}, 64'(lat), 64'(x.lat));
        check_val({tag, "_busy_cycles"}, 64'(busy_n), 64'(x.lat));
        check_val({tag, "_done"}, 64'(o_done), 64'(x.done));
        check_val({tag, "_timeout"}, 64'(o_tout), 64'(x.tout));
        check_val({tag, "_busy"}, 64'(o_busy), 64'd0);
        check_val({tag, "_cc"}, 64'(o_cc), 64'(x.cc));
        check_val({tag, "_mask"}, 64'(o_mask), 64'(x.mask));
        check_val({tag, "_snap"}, o_snap, x.snap);
    endtask

    initial begin
        exp_t e;
        n_checks = 0;
        n_pass   = 0;
        sel      = 0;
        Reset    = 1'b0;
        start_s  = 1'b0;
        clear_s  = 1'b0;
        values_s = 64'd0;

        // Reset held low, even with Start asserted.
        start_s = 1'b1;
        tick(); tick(); tick();
        start_s = 1'b0;
        check_idle_zero("reset");
        Reset = 1'b1;
        tick();
        check_idle_zero("post_reset");

        // Constant values: settles 16 RUN cycles after a 4-cycle warm-up.
        e = '{lat: 20, done: 1'b1, tout: 1'b0, cc: 16'd16, mask: 2'b00,
              snap: {32'h0000_000A, 32'h0000_0005}};
        run_case("const", 0, 0, e);

        // Start while in DONE is ignored; outputs stay frozen.
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        tick(); tick();
        check_val("done_hold_done", 64'(o_done), 64'd1);
        check_val("done_hold_busy", 64'(o_busy), 64'd0);
        check_val("done_hold_cc", 64'(o_cc), 64'd16);
        do_clear();
        check_val("clear_done", 64'(o_done), 64'd0);
        check_val("clear_cc_held", 64'(o_cc), 64'd16);

        // Channel 1 changes at RUN cycles 3 and 10.
        e = '{lat: 30, done: 1'b1, tout: 1'b0, cc: 16'd26, mask: 2'b10,
              snap: {32'h0000_0042, 32'h0000_1234}};
        run_case("ch1_change", 1, 0, e);
        do_clear();

        // Channel 0 toggles every cycle with a 20-cycle timeout.
        e = '{lat: 24, done: 1'b0, tout: 1'b1, cc: 16'd20, mask: 2'b01,
              snap: {32'h0000_0077, 32'h0000_0100}};
        run_case("timeout", 2, 1, e);
        do_clear();
        check_val("clear_tout", 64'(o_tout), 64'd0);

        // Stable and timeout hit together: Done wins.
        e = '{lat: 12, done: 1'b1, tout: 1'b0, cc: 16'd8, mask: 2'b00,
              snap: {32'h0000_003C, 32'h0000_00C3}};
        run_case("tie", 3, 2, e);
        do_clear();

        // Reset mid-RUN at CycleCount=7, then a fresh run.
        sel = 0;
        pulse_start(0);
        for (int k = 1; k <= 11; k++) tick();
        check_val("mid_run_cc", 64'(o_cc), 64'd7);
        check_val("mid_run_busy", 64'(o_busy), 64'd1);
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        check_idle_zero("mid_reset");
        e = '{lat: 20, done: 1'b1, tout: 1'b0, cc: 16'd16, mask: 2'b00,
              snap: {32'h0000_000A, 32'h0000_0005}};
        run_case("fresh", 0, 0, e);
        do_clear();

        // Clear during RUN: abort, CycleCount holds.
        pulse_start(0);
        for (int k = 1; k <= 10; k++) tick();
        do_clear();
        check_val("abort_run_busy", 64'(o_busy), 64'd0);
        check_val("abort_run_done", 64'(o_done), 64'd0);
        check_val("abort_run_cc", 64'(o_cc), 64'd6);

        // Clear during WARMUP: back to IDLE and stays there.
        pulse_start(0);
        tick(); tick();
        do_clear();
        check_val("abort_warm_busy", 64'(o_busy), 64'd0);
        check_val("abort_warm_cc", 64'(o_cc), 64'd0);
        tick();
        check_val("abort_warm_idle", 64'(o_busy), 64'd0);

        // Start and Clear together in IDLE: remain IDLE.
        start_s = 1'b1;
        clear_s = 1'b1;
        tick();
        start_s = 1'b0;
        clear_s = 1'b0;
        check_val("start_clear_busy", 64'(o_busy), 64'd0);
        tick();
        check_val("start_clear_idle", 64'(o_busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/result_monitor.md
RESULT_MONITOR -- requirements
Module: result_monitor

Interface
REQ-001 The module SHALL take parameter WIDTH, default 32, meaning bit width of one watched register channel.
REQ-002 The module SHALL take parameter CHANNELS, default 2, meaning number of watched channels (v0, v1 by default).
REQ-003 The module SHALL take parameter STABLE_CYCLES, default 16, meaning consecutive unchanged RUN cycles that declare completion (legal 1..2^CNT_W-1).
REQ-004 The module SHALL take parameter WARMUP_CYCLES, default 4, meaning cycles ignored after Start before monitoring (legal 1..255).
REQ-005 The module SHALL take parameter CNT_W, default 16, meaning width of cycle and stability counters.
REQ-006 The module SHALL take parameter TIMEOUT_CYCLES, default 65535, meaning RUN-cycle limit before timeout (legal 1..2^CNT_W-1).
REQ-007 The module SHALL have port Clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-008 The module SHALL have port Reset, input, 1, meaning synchronous, active-low reset.
REQ-009 The module SHALL have port Start, input, 1, meaning one-cycle request to begin a monitoring run.
REQ-010 The module SHALL have port Clear, input, 1, meaning abort or acknowledge; returns block to IDLE.
REQ-011 The module SHALL have port Values, input, CHANNELS*WIDTH, meaning watched registers packed, channel 0 in LSBs.
REQ-012 The module SHALL have port Busy, output, 1, meaning high in WARMUP or RUN.
REQ-013 The module SHALL have port Done, output, 1, meaning high in DONE.
REQ-014 The module SHALL have port Timeout, output, 1, meaning high in TOUT.
REQ-015 The module SHALL have port CycleCount, output, CNT_W, meaning RUN cycles elapsed, saturating at all-ones.
REQ-016 The module SHALL have port ChangeMask, output, CHANNELS, meaning sticky per-channel "changed during RUN" flags.
REQ-017 The module SHALL have port Snapshot, output, CHANNELS*WIDTH, meaning Values captured on entry to DONE or TOUT.

Function
REQ-018 The state machine SHALL have states IDLE, WARMUP, RUN, DONE, TOUT; all outputs SHALL be registered.
REQ-019 In IDLE, Start=1 and Clear=0 SHALL enter WARMUP next cycle, zeroing warmup counter, CycleCount, stability counter, ChangeMask; Snapshot holds.
REQ-020 WARMUP SHALL last exactly WARMUP_CYCLES cycles; on its last cycle the previous-value register SHALL load Values, then RUN.
REQ-021 Each RUN cycle: compare Values per channel with previous-value register; then load previous-value register with Values.
REQ-022 Any channel differs: stability counter -> 0, that channel's ChangeMask bit set (sticky); else stability counter +1.
REQ-023 Each RUN cycle CycleCount SHALL increment by 1, saturating at 2^CNT_W-1, never wrapping.
REQ-024 Stability counter's next value equals STABLE_CYCLES: next state DONE, Snapshot <= current Values.
REQ-025 CycleCount's next value equals TIMEOUT_CYCLES without REQ-024 firing: next state TOUT, Snapshot <= current Values.
REQ-026 REQ-024 and REQ-025 in the same cycle: DONE SHALL win; Timeout stays 0.
REQ-027 DONE and TOUT SHALL hold all outputs frozen until Clear=1, then IDLE; Start ignored there.
REQ-028 Clear=1 in WARMUP or RUN SHALL abort to IDLE next cycle; Snapshot unchanged, CycleCount and ChangeMask hold last values.
REQ-029 Start and Clear both high in IDLE: Clear wins, remain IDLE.
REQ-030 Start while Busy SHALL be ignored (no restart).

Reset
REQ-031 Reset=0 at a rising edge SHALL force IDLE and Busy=0, Done=0, Timeout=0, CycleCount=0, ChangeMask=0, Snapshot=0, all internal counters 0, in any state, overriding Start and Clear.
REQ-032 Reset held low SHALL keep those values; first edge with Reset=1 behaves as IDLE.

Verification
REQ-033 Defaults, Start pulse, Values constant 0x0000_0005/0x0000_000A -> Busy 4 cycles WARMUP, Done rises 16 cycles after RUN entry, CycleCount=16, ChangeMask=00, Snapshot={0xA,0x5}.
REQ-034 Defaults, channel 1 changes at RUN cycles 3 and 10, then constant -> Done at RUN cycle 26, CycleCount=26, ChangeMask=10.
REQ-035 TIMEOUT_CYCLES=20, channel 0 toggles every cycle -> Timeout=1 after 20 RUN cycles, Done=0, CycleCount=20, ChangeMask=01.
REQ-036 STABLE_CYCLES=TIMEOUT_CYCLES=8, constant Values -> Done=1, Timeout=0 (tie rule).
REQ-037 Reset=0 mid-RUN at CycleCount=7 -> next edge all outputs 0, IDLE; Start afterward begins fresh run with CycleCount from 0.
REQ-038 Clear during WARMUP, Start+Clear together in IDLE, Start in DONE -> IDLE, IDLE, DONE held respectively.
